// File: rtl/karatsuba_34_pkg.sv
// Shared constants and FSM state type for the 34x34 Karatsuba multiplier.
//   HALF_W : width of one operand half (17)
//   SUM_W  : width of a half-sum with its carry kept (18)
//   IN_W   : operand width (34)
//   OUT_W  : product width (68)
//   PROD_W : width of the shared 18x18 multiplier result (36)
package karatsuba_34_pkg;

  localparam int unsigned HALF_W = 17;
  localparam int unsigned SUM_W  = 18;
  localparam int unsigned IN_W   = 34;
  localparam int unsigned OUT_W  = 68;
  localparam int unsigned PROD_W = 2 * SUM_W;

  typedef enum logic [2:0] {
    IDLE,
    CALC_LO,
    CALC_HI,
    CALC_MID,
    COMBINE
  } state_t;

endpackage

// File: rtl/karatsuba_34_mul18.sv
// Combinational 18x18 -> 36-bit unsigned multiplier, time-shared by the
// three partial-product states of karatsuba_34.
//   a : multiplicand (18b, unsigned)
//   b : multiplier   (18b, unsigned)
//   p : product      (36b, unsigned)
module karatsuba_34_mul18
  import karatsuba_34_pkg::*;
(
  input  logic [SUM_W-1:0]  a,
  input  logic [SUM_W-1:0]  b,
  output logic [PROD_W-1:0] p
);

  assign p = {{SUM_W{1'b0}}, a} * {{SUM_W{1'b0}}, b};

endmodule

// File: rtl/karatsuba_34.sv
// Unsigned 34x34 -> 68-bit multiplier, one level of Karatsuba on 17-bit
// halves. A single 18x18 multiplier is reused across CALC_LO, CALC_HI and
// CALC_MID; the result is assembled in COMBINE. Fixed latency: start sampled
// on edge N gives a one-cycle valid_out pulse after edge N+4.
// Optional build macro: KARATSUBA34_DEBUG_EN (simulation-only trace prints).
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : one-cycle request, A/B captured when idle
//   A, B      : 34-bit unsigned operands
//   P         : 68-bit product, held until the next completion
//   valid_out : one-cycle pulse when P has just been updated
module karatsuba_34
  import karatsuba_34_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  A,
  input  logic [IN_W-1:0]  B,
  output logic [OUT_W-1:0] P,
  output logic             valid_out
);

  state_t state, state_nxt;

  logic [IN_W-1:0]   a_r, b_r;
  logic [IN_W-1:0]   z0, z2;
  logic [PROD_W-1:0] z1;

  logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
  logic [SUM_W-1:0]  sa, sb;
  logic [SUM_W-1:0]  op_a, op_b;
  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] mid;
  logic [OUT_W-1:0]  result;

  assign a_lo = a_r[HALF_W-1:0];
  assign a_hi = a_r[IN_W-1:HALF_W];
  assign b_lo = b_r[HALF_W-1:0];
  assign b_hi = b_r[IN_W-1:HALF_W];

  // Half-sums keep their carry, so the middle product needs the full 18x18.
  assign sa = {1'b0, a_hi} + {1'b0, a_lo};
  assign sb = {1'b0, b_hi} + {1'b0, b_lo};

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      CALC_LO:  begin op_a = {1'b0, a_lo}; op_b = {1'b0, b_lo}; end
      CALC_HI:  begin op_a = {1'b0, a_hi}; op_b = {1'b0, b_hi}; end
      CALC_MID: begin op_a = sa;           op_b = sb;           end
      default:  ;
    endcase
  end

  karatsuba_34_mul18 u_mul (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  // z1 >= z0 + z2 always holds, so the subtraction never wraps.
  assign mid    = z1 - {2'b00, z2} - {2'b00, z0};
  assign result = {z2, {IN_W{1'b0}}}
                + {{(OUT_W-PROD_W-HALF_W){1'b0}}, mid, {HALF_W{1'b0}}}
                + {{IN_W{1'b0}}, z0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = CALC_LO;
      CALC_LO:  state_nxt = CALC_HI;
      CALC_HI:  state_nxt = CALC_MID;
      CALC_MID: state_nxt = COMBINE;
      COMBINE:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      z0        <= '0;
      z2        <= '0;
      z1        <= '0;
      P         <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r <= A;
            b_r <= B;
          end
        end
        CALC_LO:  z0 <= prod[IN_W-1:0];
        CALC_HI:  z2 <= prod[IN_W-1:0];
        CALC_MID: z1 <= prod;
        COMBINE: begin
          P         <= result;
          valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef KARATSUBA34_DEBUG_EN
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && start)
      $display("[karatsuba_34] capture A=%h B=%h a_hi=%h a_lo=%h b_hi=%h b_lo=%h sa=%h sb=%h",
               A, B, A[IN_W-1:HALF_W], A[HALF_W-1:0], B[IN_W-1:HALF_W], B[HALF_W-1:0],
               {1'b0, A[IN_W-1:HALF_W]} + {1'b0, A[HALF_W-1:0]},
               {1'b0, B[IN_W-1:HALF_W]} + {1'b0, B[HALF_W-1:0]});
    if (!rst && state == COMBINE)
      $display("[karatsuba_34] combine z0=%h z2=%h z1=%h mid=%h P=%h",
               z0, z2, z1, mid, result);
  end
`endif

endmodule

// File: tb/tb_karatsuba_34.sv
module tb_karatsuba_34;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [33:0] A = '0;
  logic [33:0] B = '0;
  logic [67:0] P;
  logic        valid_out;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  karatsuba_34 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (A),
    .B         (B),
    .P         (P),
    .valid_out (valid_out)
  );

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a request accepted while no job is outstanding completes four
  // edges later with the exact product; any other start is dropped.
  int          busy = 0;
  logic [67:0] pend_p = '0;
  logic [67:0] exp_p = '0;
  logic        exp_valid = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy = 0;
      exp_p = '0;
      exp_valid = 1'b0;
    end else begin
      bit idle;
      idle = (busy == 0);
      exp_valid = 1'b0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          exp_p = pend_p;
          exp_valid = 1'b1;
        end
      end
      if (idle && start) begin
        pend_p = {34'b0, A} * {34'b0, B};
        busy = 4;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("valid_out", {67'b0, valid_out}, {67'b0, exp_valid});
      check("P", P, exp_p);
    end
  end

  task automatic set_in(input logic s, input logic [33:0] a, input logic [33:0] b);
    @(posedge clk); #1;
    start = s; A = a; B = b;
  endtask

  function automatic logic [33:0] rnd34();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 4))
      0:       return '1;
      1:       return '0;
      default: return r[33:0];
    endcase
  endfunction

  // Counts negedges until valid_out; 12 means it never arrived.
  task automatic wait_valid(output int lat);
    for (lat = 0; lat < 12; lat++) begin
      @(negedge clk);
      if (valid_out) break;
    end
  endtask

  task automatic run_lit(input logic [33:0] a, input logic [33:0] b,
                         input logic [67:0] lit, input string name);
    int lat;
    set_in(1'b1, a, b);
    set_in(1'b0, rnd34(), rnd34());
    wait_valid(lat);
    check({name, "_latency"}, 68'(lat), 68'd4);
    check({name, "_P"}, P, lit);
    check({name, "_model"}, exp_p, lit);
  endtask

  initial begin
    int lat;
    int pulses;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_valid", {67'b0, valid_out}, 68'd0);
    check("reset_P", P, 68'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    checking = 1'b1;

    run_lit(34'd12345, 34'd6789, 68'd83810205, "basic");
    run_lit(34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 68'hF_FFFF_FFF8_0000_0001, "allones");
    run_lit(34'h2_0000, 34'h1_FFFF, 68'h3_FFFE_0000, "halfedge");
    run_lit(34'd0, 34'h3_FFFF_FFFF, 68'd0, "zero");

    // Start while busy is ignored; operand changes after capture are ignored.
    set_in(1'b1, 34'd5, 34'd7);
    set_in(1'b0, 34'd100, 34'd200);
    set_in(1'b1, 34'd9, 34'd9);
    set_in(1'b0, 34'd11, 34'd13);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid_out) begin
        pulses++;
        check("ignore_P", P, 68'd35);
      end
    end
    check("ignore_pulses", 68'(pulses), 68'd1);

    // Reset two cycles after start aborts the job.
    set_in(1'b1, 34'd5, 34'd7);
    set_in(1'b0, 34'd0, 34'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (valid_out) pulses++;
    end
    check("abort_pulses", 68'(pulses), 68'd0);
    check("abort_P", P, 68'd0);
    run_lit(34'd3, 34'd4, 68'd12, "after_abort");

    // Back-to-back: new start in the valid_out cycle.
    set_in(1'b1, 34'd5, 34'd7);
    set_in(1'b0, 34'd0, 34'd0);
    wait_valid(lat);
    check("b2b_first_latency", 68'(lat), 68'd4);
    check("b2b_first_P", P, 68'd35);
    start = 1'b1; A = 34'd2; B = 34'd3;
    @(posedge clk); #1;
    start = 1'b0; A = 34'd77; B = 34'd88;
    wait_valid(lat);
    check("b2b_second_latency", 68'(lat), 68'd4);
    check("b2b_second_P", P, 68'd6);

    // Random traffic against the reference, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      A = rnd34();
      B = rnd34();
      rst = ($urandom_range(0, 59) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
